instr_sequencer: RTL and testbench

Fetch/decode/execute controller for the 16-word program ROM. Owns the 4-bit program counter and drives the ROM address. Latches each instruction, splits it into fields, and handshakes each non-control-flow instruction with the register/ALU datapath. Executes jmp and br internally. Supports free-run and single-step operation.

---
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for a 16-word program ROM: owns the PC,
// executes jmp/br internally and handshakes all other opcodes with the datapath.
module instr_sequencer #(
  parameter int         ADDR_W = 4,
  parameter int         INST_W = 16,
  parameter logic [3:0] OP_JMP = 4'b1000,
  parameter logic [3:0] OP_BR  = 4'b1100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              zero_flag,
  input  logic              exec_done,
  output logic              exec_start,
  output logic [3:0]        opcode,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [7:0]        imm,
  output logic              busy,
  output logic              retire
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [INST_W-1:0]   ir;
  logic                step_mode, step_mode_n;
  logic                load_ir;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   pc_inc;

  assign opcode   = ir[15:12];
  assign rd       = ir[11:9];
  assign rs       = ir[8:6];
  assign imm      = ir[7:0];
  assign rom_addr = pc;
  assign busy     = (state != S_IDLE);
  assign target   = ADDR_W'(ir[11:8]);
  assign pc_inc   = pc + ADDR_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    step_mode_n = step_mode;
    load_ir     = 1'b0;
    exec_start  = 1'b0;
    retire      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_n     = S_FETCH;
          step_mode_n = 1'b0;
        end else if (step) begin
          state_n     = S_FETCH;
          step_mode_n = 1'b1;
        end
      end
      S_FETCH: begin
        load_ir = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_JMP) begin
          pc_n   = target;
          retire = 1'b1;
        end else if (opcode == OP_BR) begin
          pc_n   = zero_flag ? target : pc_inc;
          retire = 1'b1;
        end else begin
          exec_start = 1'b1;
          if (exec_done) begin
            pc_n   = pc_inc;
            retire = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          pc_n   = pc_inc;
          retire = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Instruction boundary: a single step always parks in IDLE afterwards.
    if (retire) begin
      step_mode_n = 1'b0;
      state_n     = (step_mode || !run) ? S_IDLE : S_FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      step_mode <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      step_mode <= step_mode_n;
      if (load_ir) ir <= rom_data;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: an instruction-level reference model
// predicts per-cycle outputs under directed and randomized programs.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, step, zero_flag, exec_done;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        exec_start, busy, retire;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs;
  logic [7:0]  imm;

  logic [15:0] rom [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  mpc;
  logic        smode;

  always #5 clk = ~clk;
  always_comb rom_data = rom[rom_addr];

  instr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .zero_flag  (zero_flag),
    .exec_done  (exec_done),
    .exec_start (exec_start),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .imm        (imm),
    .busy       (busy),
    .retire     (retire)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s pc=%0d got=%0h expected=%0h t=%0t", tag, mpc, got, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic check_fields(input string tag, input logic [15:0] inst);
    check({tag, ".opcode"}, 32'(opcode), 32'(inst[15:12]));
    check({tag, ".rd"},     32'(rd),     32'(inst[11:9]));
    check({tag, ".rs"},     32'(rs),     32'(inst[8:6]));
    check({tag, ".imm"},    32'(imm),    32'(inst[7:0]));
  endtask

  task automatic load_demo_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1E09; rom[1] = 16'hFE00; rom[2] = 16'h100A; rom[3] = 16'hF000;
    rom[4] = 16'hE1C0; rom[5] = 16'hF000; rom[6] = 16'h8000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b1; step = 1'b1; exec_done = 1'b1; zero_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; run = 1'b0; step = 1'b0;
    mpc = 4'd0; smode = 1'b0;
    #1;
    check("reset.busy",       32'(busy),       32'd0);
    check("reset.exec_start", 32'(exec_start), 32'd0);
    check("reset.retire",     32'(retire),     32'd0);
    check("reset.rom_addr",   32'(rom_addr),   32'd0);
    check_fields("reset", 16'h0000);
  endtask

  // One cycle in IDLE; returns with the DUT heading to FETCH if run or step.
  task automatic idle_cycle(input logic run_v, input logic step_v);
    @(negedge clk);
    run = run_v; step = step_v; exec_done = rbit(); zero_flag = rbit();
    #1;
    check("idle.busy",       32'(busy),       32'd0);
    check("idle.exec_start", 32'(exec_start), 32'd0);
    check("idle.retire",     32'(retire),     32'd0);
    check("idle.rom_addr",   32'(rom_addr),   32'(mpc));
    if (run_v) smode = 1'b0;
    else if (step_v) smode = 1'b1;
  endtask

  // One whole instruction starting at its FETCH cycle. lat = cycles waited
  // for exec_done after issue; cont_run = run level at the retire cycle.
  task automatic instr(input int lat, input logic zf, input logic cont_run,
                       output logic went_idle);
    logic [15:0] inst;
    logic [3:0]  op;
    logic        ctrl, ret_now;
    inst = rom[mpc];
    op   = inst[15:12];
    ctrl = (op == 4'h8) || (op == 4'hC);

    @(negedge clk);
    run = rbit(); step = rbit(); exec_done = rbit(); zero_flag = rbit();
    #1;
    check("fetch.busy",       32'(busy),       32'd1);
    check("fetch.rom_addr",   32'(rom_addr),   32'(mpc));
    check("fetch.exec_start", 32'(exec_start), 32'd0);
    check("fetch.retire",     32'(retire),     32'd0);

    @(negedge clk);
    run = rbit(); step = rbit(); exec_done = rbit(); zero_flag = rbit();
    #1;
    check_fields("decode", inst);
    check("decode.exec_start", 32'(exec_start), 32'd0);
    check("decode.retire",     32'(retire),     32'd0);

    @(negedge clk);
    ret_now   = ctrl || (lat == 0);
    zero_flag = zf;
    step      = rbit();
    exec_done = (lat == 0) ? 1'b1 : (ctrl ? rbit() : 1'b0);
    run       = ret_now ? cont_run : rbit();
    #1;
    check_fields("exec", inst);
    check("exec.exec_start", 32'(exec_start), 32'(!ctrl));
    check("exec.retire",     32'(retire),     32'(ret_now));
    check("exec.busy",       32'(busy),       32'd1);

    if (!ret_now) begin
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        exec_done = (i == lat);
        run       = (i == lat) ? cont_run : rbit();
        step      = rbit();
        zero_flag = rbit();
        #1;
        check("wait.exec_start", 32'(exec_start), 32'd0);
        check("wait.retire",     32'(retire),     32'(i == lat));
        check("wait.rom_addr",   32'(rom_addr),   32'(mpc));
        check_fields("wait", inst);
      end
    end

    if (op == 4'h8)                mpc = inst[11:8];
    else if (op == 4'hC && zf)     mpc = inst[11:8];
    else                           mpc = 4'((int'(mpc) + 1) % 16);
    went_idle = smode || !cont_run;
    smode     = 1'b0;
  endtask

  initial begin
    logic idle_next;
    rst = 1'b1; run = 1'b0; step = 1'b0; zero_flag = 1'b0; exec_done = 1'b0;
    load_demo_rom();
    do_reset();

    // Demo program, exec_done tied high: PC 0..5 issue, PC 6 jumps to 0.
    idle_cycle(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) instr(0, 1'b0, 1'b1, idle_next);
    check("jmp.target", 32'(mpc), 32'd0);

    // Datapath op at PC 0 held four cycles in WAIT.
    instr(4, 1'b0, 1'b1, idle_next);
    check("wait4.pc", 32'(mpc), 32'd1);

    // Branch at PC 3: taken to 15, wrap to 0, then not taken to 4.
    rom[3]  = 16'hCF00;
    rom[15] = 16'h1000;
    while (mpc != 4'd3) instr(0, 1'b0, 1'b1, idle_next);
    instr(0, 1'b1, 1'b1, idle_next);
    check("br.taken", 32'(mpc), 32'd15);
    instr(1, 1'b0, 1'b1, idle_next);
    check("wrap", 32'(mpc), 32'd0);
    while (mpc != 4'd3) instr(0, 1'b0, 1'b1, idle_next);
    instr(0, 1'b0, 1'b0, idle_next);
    check("br.not_taken", 32'(mpc), 32'd4);

    // Single stepping: one instruction per pulse, even if run rises at retire.
    for (int k = 0; k < 4; k++) begin
      idle_cycle(1'b0, 1'b0);
      idle_cycle(1'b0, 1'b1);
      instr($urandom_range(3, 0), rbit(), rbit(), idle_next);
      check("step.went_idle", 32'(idle_next), 32'd1);
    end

    // run dropped while waiting: finish, then stay in IDLE.
    idle_cycle(1'b0, 1'b1);
    instr(3, 1'b0, 1'b0, idle_next);
    repeat (3) idle_cycle(1'b0, 1'b0);

    // Randomized programs and handshakes.
    for (int i = 0; i < 16; i++) begin
      rom[i] = 16'($urandom);
      if ($urandom_range(3, 0) == 0) rom[i][15:12] = rbit() ? 4'h8 : 4'hC;
    end
    idle_cycle(1'b1, 1'b0);
    for (int n = 0; n < 300; n++) begin
      instr($urandom_range(4, 0), rbit(), ($urandom_range(3, 0) != 0), idle_next);
      if (idle_next) begin
        for (int j = 0; j < 3; j++) idle_cycle(1'b0, 1'b0);
        if (rbit()) idle_cycle(1'b1, rbit());
        else        idle_cycle(1'b0, 1'b1);
      end
    end
    repeat (8) @(negedge clk);

    // Reset while waiting at PC 5; a late exec_done must not retire.
    load_demo_rom();
    do_reset();
    idle_cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) instr(0, 1'b0, 1'b1, idle_next);
    check("rstwait.pc", 32'(mpc), 32'd5);
    repeat (2) begin
      @(negedge clk);
      run = 1'b1; exec_done = 1'b0;
    end
    @(negedge clk);
    exec_done = 1'b0;
    #1;
    check("rstwait.exec_start", 32'(exec_start), 32'd1);
    @(negedge clk);
    #1;
    check("rstwait.in_wait", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b0; exec_done = 1'b1;
    mpc = 4'd0;
    #1;
    check("rstwait.busy",       32'(busy),       32'd0);
    check("rstwait.rom_addr",   32'(rom_addr),   32'd0);
    check("rstwait.exec_start", 32'(exec_start), 32'd0);
    check("rstwait.retire",     32'(retire),     32'd0);
    @(negedge clk);
    exec_done = 1'b0;
    #1;
    check("rstwait.late_retire", 32'(retire), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
